// File: rtl/dac_pkg.sv
// Shared widths, full-scale code, FSM state enum and segment payload for the
// DAC segment decoder.
package dac_pkg;

   localparam int unsigned LSB_W    = 8;
   localparam int unsigned THERM_W  = 17;
   localparam int unsigned MSB_W    = 5;
   localparam int unsigned CODE_W   = 13;
   localparam int unsigned CODE_MAX = 4607;

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_WAKE     = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_SHUTDOWN = 2'd3
   } state_t;

   typedef struct packed {
      logic [THERM_W-1:0] therm;
      logic [LSB_W-1:0]   lsb;
   } seg_t;

   // Clamp a code to the full-scale value.
   function automatic logic [CODE_W-1:0] saturate(input logic [CODE_W-1:0] code,
                                                   input logic [CODE_W-1:0] max_code);
      return (code > max_code) ? max_code : code;
   endfunction

endpackage

// File: rtl/dac_segment_decoder_therm_encoder.sv
// Binary-to-thermometer conversion of the MSB segment: bit i set for all i < bin.
module therm_encoder
   import dac_pkg::*;
(
   input  logic [MSB_W-1:0]   bin,
   output logic [THERM_W-1:0] therm_c
);

   always_comb begin
      therm_c = '0;
      for (int i = 0; i < int'(THERM_W); i++) begin
         therm_c[i] = (bin > MSB_W'(i));
      end
   end

endmodule

// File: rtl/dac_segment_decoder.sv
// Power-sequenced segment decoder: saturates accepted codes, splits them into a
// binary LSB segment and a thermometer MSB segment, with complementary outputs.
module dac_segment_decoder #(
   parameter int unsigned WAKE_CYCLES = 16,
   parameter int unsigned CODE_MAX    = dac_pkg::CODE_MAX
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [dac_pkg::CODE_W-1:0]   code_in,
   input  logic                         code_valid,
   output logic                         code_ready,
   output logic [dac_pkg::LSB_W-1:0]    datain,
   output logic [dac_pkg::LSB_W-1:0]    datainb,
   output logic [dac_pkg::THERM_W-1:0]  datatherm,
   output logic [dac_pkg::THERM_W-1:0]  datathermb,
   output logic                         pdb,
   output logic                         sat
);

   import dac_pkg::*;

   localparam int unsigned WCNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_CYCLES - 1);
   localparam logic [CODE_W-1:0] MAX_CODE  = CODE_W'(CODE_MAX);

   state_t              state, state_nx;
   logic [WCNT_W-1:0]   wake_cnt, wake_cnt_nx;
   logic                sd_cnt, sd_cnt_nx;
   logic                pdb_nx, ready_nx;

   logic                transfer_c;
   logic [CODE_W-1:0]   stage1, stage1_nx;
   logic [THERM_W-1:0]  therm_c;
   seg_t                seg_q, segb_q, seg_nx;

   // State and sequencing registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_OFF;
         wake_cnt   <= '0;
         sd_cnt     <= 1'b0;
         pdb        <= 1'b0;
         code_ready <= 1'b0;
      end else begin
         state      <= state_nx;
         wake_cnt   <= wake_cnt_nx;
         sd_cnt     <= sd_cnt_nx;
         pdb        <= pdb_nx;
         code_ready <= ready_nx;
      end
   end

   // Next state; pdb/code_ready are registered copies of the next state's decode
   always_comb begin
      state_nx    = state;
      wake_cnt_nx = wake_cnt;
      sd_cnt_nx   = 1'b0;
      case (state)
         ST_OFF: begin
            if (en) state_nx = ST_WAKE;
         end
         ST_WAKE: begin
            if (!en) begin
               state_nx    = ST_OFF;
               wake_cnt_nx = '0;
            end else if (wake_cnt == WAKE_LAST) begin
               state_nx    = ST_ACTIVE;
               wake_cnt_nx = '0;
            end else begin
               wake_cnt_nx = wake_cnt + WCNT_W'(1);
            end
         end
         ST_ACTIVE: begin
            if (!en) state_nx = ST_SHUTDOWN;
         end
         ST_SHUTDOWN: begin
            if (sd_cnt) state_nx = ST_OFF;
            else        sd_cnt_nx = 1'b1;
         end
         default: state_nx = ST_OFF;
      endcase
      pdb_nx   = (state_nx != ST_OFF);
      ready_nx = (state_nx == ST_ACTIVE);
   end

   assign transfer_c = code_valid && code_ready;

   // Stage 1 holds its code only while active; any other state feeds zero code
   always_comb begin
      stage1_nx = '0;
      if (transfer_c)              stage1_nx = saturate(code_in, MAX_CODE);
      else if (state == ST_ACTIVE) stage1_nx = stage1;
   end

   therm_encoder u_therm (
      .bin     (stage1[CODE_W-1:LSB_W]),
      .therm_c (therm_c)
   );

   assign seg_nx.lsb   = stage1[LSB_W-1:0];
   assign seg_nx.therm = therm_c;

   // Saturate stage, then decode stage with complementary copies
   always_ff @(posedge clk) begin
      if (rst) begin
         stage1 <= '0;
         sat    <= 1'b0;
         seg_q  <= '0;
         segb_q <= '1;
      end else begin
         stage1 <= stage1_nx;
         if (transfer_c) sat <= (code_in > MAX_CODE);
         seg_q  <= seg_nx;
         segb_q <= ~seg_nx;
      end
   end

   assign datain     = seg_q.lsb;
   assign datatherm  = seg_q.therm;
   assign datainb    = segb_q.lsb;
   assign datathermb = segb_q.therm;

endmodule

// File: tb/tb_dac_segment_decoder.sv
// Self-checking bench: directed power/decode scenarios plus randomized traffic
// against a cycle-level behavioural model.
module tb_dac_segment_decoder;

   localparam int WAKE = 16;
   localparam int FS   = 4607;
   localparam int M_OFF = 0, M_WAKE = 1, M_ACTIVE = 2, M_SD = 3;

   logic        clk = 1'b0;
   logic        rst, en, code_valid;
   logic [12:0] code_in;
   logic        code_ready, pdb, sat;
   logic [7:0]  datain, datainb;
   logic [16:0] datatherm, datathermb;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   int mode, left, p1, p2;
   bit m_sat;

   always #5 clk = ~clk;

   dac_segment_decoder #(.WAKE_CYCLES(WAKE), .CODE_MAX(FS)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .code_in    (code_in),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .datain     (datain),
      .datainb    (datainb),
      .datatherm  (datatherm),
      .datathermb (datathermb),
      .pdb        (pdb),
      .sat        (sat)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int therm_of(input int code);
      int m = code / 256;
      return (m >= 17) ? 32'h1FFFF : ((1 << m) - 1);
   endfunction

   // Advance the model by one rising edge using the inputs sampled at that edge
   task automatic model_edge();
      if (rst) begin
         mode = M_OFF; left = 0; p1 = 0; p2 = 0; m_sat = 0;
      end else begin
         bit xfer = (mode == M_ACTIVE) && code_valid;
         p2 = p1;
         if (xfer) begin
            p1    = (int'(code_in) > FS) ? FS : int'(code_in);
            m_sat = (int'(code_in) > FS);
         end else if (mode != M_ACTIVE) begin
            p1 = 0;
         end
         case (mode)
            M_OFF:    if (en) begin mode = M_WAKE; left = WAKE; end
            M_WAKE:   if (!en) mode = M_OFF;
                      else begin left--; if (left == 0) mode = M_ACTIVE; end
            M_ACTIVE: if (!en) begin mode = M_SD; left = 2; end
            default:  begin left--; if (left == 0) mode = M_OFF; end
         endcase
      end
   endtask

   task automatic compare_all();
      int lsb = p2 % 256;
      int th  = therm_of(p2);
      check("pdb",        32'(pdb),        32'(mode != M_OFF));
      check("code_ready", 32'(code_ready), 32'(mode == M_ACTIVE));
      check("sat",        32'(sat),        32'(m_sat));
      check("datain",     32'(datain),     32'(lsb));
      check("datainb",    32'(datainb),    32'(255 - lsb));
      check("datatherm",  32'(datatherm),  32'(th));
      check("datathermb", 32'(datathermb), 32'(32'h1FFFF - th));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic send(input int code);
      code_in = 13'(code); code_valid = 1'b1;
      step();
      code_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; code_valid = 1'b0; code_in = '0;
      mode = M_OFF; left = 0; p1 = 0; p2 = 0; m_sat = 0;
      step(); step();
      check("rst_datainb",    32'(datainb),    32'hFF);
      check("rst_datathermb", 32'(datathermb), 32'h1FFFF);
      check("rst_pdb",        32'(pdb),        32'h0);
      rst = 1'b0;
      step();

      // power-up: pdb next cycle, ready after 16 wake cycles
      en = 1'b1;
      step();
      check("wake_pdb", 32'(pdb), 32'h1);
      for (int i = 0; i < WAKE - 1; i++) begin
         step();
         check("wake_not_ready", 32'(code_ready), 32'h0);
         check("wake_zero", 32'(datatherm), 32'h0);
      end
      step();
      check("wake_ready", 32'(code_ready), 32'h1);

      // mid-scale decode
      send(13'h0A5C);
      step();
      check("dec_datain",     32'(datain),     32'h5C);
      check("dec_datainb",    32'(datainb),    32'hA3);
      check("dec_datatherm",  32'(datatherm),  32'h003FF);
      check("dec_datathermb", 32'(datathermb), 32'h1FC00);
      step(); step();
      check("hold_datain", 32'(datain), 32'h5C);

      // saturation then zero
      send(8191);
      step();
      check("sat_flag",   32'(sat),       32'h1);
      check("sat_datain", 32'(datain),    32'hFF);
      check("sat_therm",  32'(datatherm), 32'h1FFFF);
      send(0);
      step();
      check("zero_sat",   32'(sat),       32'h0);
      check("zero_therm", 32'(datatherm), 32'h0);
      check("zero_lsb",   32'(datain),    32'h0);

      // shutdown: two cycles powered, then off
      send(13'h0321);
      step();
      en = 1'b0;
      step();
      check("sd1_pdb",   32'(pdb),        32'h1);
      check("sd1_ready", 32'(code_ready), 32'h0);
      en = 1'b1;
      step();
      check("sd2_pdb", 32'(pdb), 32'h1);
      step();
      check("sd_off_pdb",   32'(pdb),       32'h0);
      check("sd_off_therm", 32'(datatherm), 32'h0);

      // abort wake at cycle 5 and restart a full wake
      en = 1'b0; step();
      en = 1'b1;
      for (int i = 0; i < 6; i++) step();
      en = 1'b0; step();
      check("abort_pdb", 32'(pdb), 32'h0);
      en = 1'b1;
      for (int i = 0; i < WAKE; i++) step();
      check("rewake_not_ready", 32'(code_ready), 32'h0);
      step();
      check("rewake_ready", 32'(code_ready), 32'h1);

      // reset one cycle after a transfer drops the code
      send(13'h0F0F);
      rst = 1'b1;
      step();
      check("rstx_datain",  32'(datain),  32'h00);
      check("rstx_datainb", 32'(datainb), 32'hFF);
      check("rstx_ready",   32'(code_ready), 32'h0);
      rst = 1'b0;
      step();
      check("rstx_never", 32'(datain), 32'h00);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int r = $urandom_range(0, 7);
         if ($urandom_range(0, 99) < 3) en = ~en;
         rst        = ($urandom_range(0, 199) == 0);
         code_valid = $urandom_range(0, 1);
         case (r)
            0: code_in = 13'(FS);
            1: code_in = 13'(FS + 1);
            2: code_in = 13'd0;
            3: code_in = 13'd8191;
            default: code_in = 13'($urandom_range(0, 8191));
         endcase
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dac_segment_decoder.md
DAC_SEGMENT_DECODER -- requirements
Module: dac_segment_decoder

Interface
REQ-001 SHALL have parameter WAKE_CYCLES, default 16, meaning cycles from power-up request to accepting codes.
REQ-002 SHALL have parameter CODE_MAX, default 4607, meaning full-scale code (17 thermometer units x 256 + 255).
REQ-003 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  in  1  converter enable request.
REQ-006 SHALL have port code_in  in  13  unsigned DAC code.
REQ-007 SHALL have port code_valid  in  1  code_in valid.
REQ-008 SHALL have port code_ready  out  1  block accepts code this cycle.
REQ-009 SHALL have ports datain/datainb  out  8 each  binary LSB segment and its complement, to driver stage.
REQ-010 SHALL have ports datatherm/datathermb  out  17 each  thermometer MSB segment and its complement, to driver stage.
REQ-011 SHALL have port pdb  out  1  power-down negate to driver stage.
REQ-012 SHALL have port sat  out  1  last accepted code exceeded CODE_MAX.

Function
REQ-013 SHALL implement FSM states OFF, WAKE, ACTIVE, SHUTDOWN.
REQ-014 OFF: pdb=0, code_ready=0; en=1 -> WAKE next cycle.
REQ-015 WAKE: pdb=1, code_ready=0, wake counter counts WAKE_CYCLES cycles then -> ACTIVE; en=0 during WAKE -> OFF next cycle, counter cleared.
REQ-016 ACTIVE: pdb=1, code_ready=1; transfer occurs when code_valid && code_ready; en=0 -> SHUTDOWN.
REQ-017 SHUTDOWN: pdb=1, code_ready=0, zero code forced into pipeline for exactly 2 cycles, then -> OFF; en ignored during SHUTDOWN.
REQ-018 Accepted code SHALL be saturated: code_in > CODE_MAX -> CODE_MAX and sat=1; otherwise sat=0; sat updates only on transfer.
REQ-019 Decode: datain = code[7:0]; MSB value m = code[12:8] (0..17); datatherm[i]=1 for all i<m, 0 otherwise.
REQ-020 Pipeline SHALL be two registered stages (saturate, then decode); outputs reflect an accepted code exactly 2 cycles after transfer.
REQ-021 With no transfer in ACTIVE, outputs SHALL hold the last decoded code.
REQ-022 datainb SHALL equal ~datain and datathermb SHALL equal ~datatherm on every cycle, including reset.
REQ-023 In OFF and WAKE, segment outputs SHALL be the zero code (datain=0, datatherm=0).
REQ-024 Codes presented while code_ready=0 SHALL be ignored, not queued.

Reset
REQ-025 rst=1 SHALL force state OFF, wake counter 0, both pipeline stages zero code, sat=0, pdb=0, code_ready=0, datain=0x00, datainb=0xFF, datatherm=0, datathermb=17'h1FFFF.
REQ-026 rst mid-transfer or mid-SHUTDOWN SHALL abandon the operation; no partial code reaches outputs.

Structure
REQ-027 Segment widths (8, 17), CODE_MAX and FSM state enum SHALL live in a shared package dac_pkg.
REQ-028 Binary-to-thermometer conversion SHALL be one sub-module, therm_encoder (5-bit in, 17-bit out, combinational).

Verification
REQ-029 Reset then en=1 -> pdb=1 next cycle, code_ready=1 after 16 WAKE cycles, outputs zero code throughout.
REQ-030 ACTIVE, code 0x0A5C (m=10, LSB 0x5C) -> 2 cycles later datain=0x5C, datainb=0xA3, datatherm=17'h003FF, datathermb=17'h1FC00.
REQ-031 Code 8191 -> sat=1, outputs datain=0xFF, datatherm=17'h1FFFF; next code 0 -> sat=0, all zero.
REQ-032 en=0 in ACTIVE -> 2 SHUTDOWN cycles with pdb=1 and zero code, then pdb=0, code_ready=0.
REQ-033 en=0 at WAKE cycle 5 -> OFF next cycle; re-enable restarts full 16-cycle wake.
REQ-034 rst asserted one cycle after a transfer -> next cycle all outputs at reset values, transferred code never appears.
